// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: word geometry and the store-buffer entry layout.
package riscv_mem_pkg;

    localparam int XLEN              = 32;
    localparam int STB_DEPTH_DEFAULT = 4;
    localparam int WORD_OFS          = 2;

    typedef struct packed {
        logic                     valid;
        logic [XLEN-1:WORD_OFS]   addr;
        logic [XLEN-1:0]          data;
    } stb_entry_t;

endpackage

// File: rtl/stb_fwd_match.sv
// Youngest-first load-forwarding match over the store-buffer entries (purely combinational).
module stb_fwd_match
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = STB_DEPTH_DEFAULT,
    parameter int ADDR_W = XLEN
) (
    input  stb_entry_t                 i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_wr_ptr,
    input  logic [ADDR_W-1:0]          i_ld_addr,
    output logic                       o_hit,
    output logic [XLEN-1:0]            o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;
    logic             w_unused_ofs;

    assign w_unused_ofs = ^i_ld_addr[WORD_OFS-1:0];

    // Walk from oldest (wr_ptr-DEPTH) to youngest (wr_ptr-1) so later matches override.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = i_wr_ptr - PTR_W'(1) - PTR_W'(k);
            if (i_entries[w_idx].valid &&
                (i_entries[w_idx].addr == i_ld_addr[ADDR_W-1:WORD_OFS])) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: accepts core stores in order, drains oldest-first to Data_Memory,
// and forwards the youngest pending matching store to loads.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = STB_DEPTH_DEFAULT,
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wd,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_fwd_hit,
    output logic [DATA_W-1:0]        ld_fwd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a store transfers on a rising edge where st_valid && st_ready; the core
    // holds st_addr/st_data until then. A drain transfers on every edge where mem_we is high.

    stb_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_unused_ofs;

    assign w_unused_ofs = ^st_addr[WORD_OFS-1:0];

    assign w_empty  = (r_count == '0);
    assign st_ready = (r_count < CNT_W'(DEPTH));
    assign mem_we   = !w_empty && mem_ready;
    assign w_enq    = st_valid && st_ready;
    assign w_deq    = mem_we;
    assign empty    = w_empty;
    assign count    = r_count;

    // Slot at rd_ptr holds stale data when empty, so force the write port quiet.
    assign mem_addr = w_empty ? '0 : {r_entries[r_rd_ptr].addr, 2'b00};
    assign mem_wd   = w_empty ? '0 : r_entries[r_rd_ptr].data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_entries[r_wr_ptr].valid <= 1'b1;
                r_entries[r_wr_ptr].addr  <= st_addr[ADDR_W-1:WORD_OFS];
                r_entries[r_wr_ptr].data  <= st_data;
                r_wr_ptr                  <= r_wr_ptr + PTR_W'(1);
            end
            // wr_ptr == rd_ptr only when empty or full, so enqueue and drain never share a slot.
            if (w_deq) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr                  <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    stb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fwd_match (
        .i_entries (r_entries),
        .i_wr_ptr  (r_wr_ptr),
        .i_ld_addr (ld_addr),
        .o_hit     (ld_fwd_hit),
        .o_data    (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: per-scenario tasks plus a negedge scoreboard
// that predicts every memory write from the accepted stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        st_valid  = 1'b0;
    logic [31:0] st_addr   = '0;
    logic [31:0] st_data   = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] ld_addr   = '0;

    logic        st_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        empty;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    int m_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .ld_addr     (ld_addr),
        .ld_fwd_hit  (ld_fwd_hit),
        .ld_fwd_data (ld_fwd_data),
        .empty       (empty),
        .count       (count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard: inputs change only at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        logic exp_we;
        logic enq;
        logic [31:0] ea;
        logic [31:0] ed;
        if (reset) begin
            m_cnt = 0;
            exp_addr_q.delete();
            exp_data_q.delete();
        end else begin
            exp_we = (m_cnt != 0) && mem_ready;
            enq    = st_valid && (m_cnt < DEPTH);
            n_cmp++; if (st_ready !== (m_cnt < DEPTH)) begin n_err++; $display("FAIL sb_st_ready: got %b expected %b", st_ready, (m_cnt < DEPTH)); end
            n_cmp++; if (count !== 3'(m_cnt)) begin n_err++; $display("FAIL sb_count: got %0d expected %0d", count, m_cnt); end
            n_cmp++; if (empty !== (m_cnt == 0)) begin n_err++; $display("FAIL sb_empty: got %b expected %b", empty, (m_cnt == 0)); end
            n_cmp++; if (mem_we !== exp_we) begin n_err++; $display("FAIL sb_mem_we: got %b expected %b", mem_we, exp_we); end
            if (exp_we) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                n_cmp++; if (mem_addr !== ea) begin n_err++; $display("FAIL sb_mem_addr: got %h expected %h", mem_addr, ea); end
                n_cmp++; if (mem_wd !== ed) begin n_err++; $display("FAIL sb_mem_wd: got %h expected %h", mem_wd, ed); end
            end else if (m_cnt == 0) begin
                n_cmp++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_err++; $display("FAIL sb_idle_port: got %h/%h expected 0/0", mem_addr, mem_wd); end
            end
            if (enq) begin
                exp_addr_q.push_back({st_addr[31:2], 2'b00});
                exp_data_q.push_back(st_data);
            end
            m_cnt = m_cnt + (enq ? 1 : 0) - (exp_we ? 1 : 0);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain_all();
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && empty !== 1'b1; i++) tick();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_timeout: empty got %b expected 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (st_ready !== 1'b1 || empty !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_flags: got rdy=%b empty=%b we=%b expected 1 1 0", st_ready, empty, mem_we); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (ld_fwd_hit !== 1'b0 || ld_fwd_data !== 32'h0) begin n_err++; $display("FAIL reset_fwd: got %b/%h expected 0/0", ld_fwd_hit, ld_fwd_data); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_err++; $display("FAIL reset_port: got %h/%h expected 0/0", mem_addr, mem_wd); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL post_reset: got count=%0d empty=%b expected 0 1", count, empty); end
    endtask

    task automatic test_fill_and_drain();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        n_cmp++; if (count !== 3'd4 || st_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got count=%0d rdy=%b expected 4 0", count, st_ready); end
        put_store(32'h110, 32'hA4);
        n_cmp++; if (count !== 3'd4 || st_ready !== 1'b0) begin n_err++; $display("FAIL fill_hold: got count=%0d rdy=%b expected 4 0", count, st_ready); end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * i) || mem_wd !== 32'hA0 + 32'(i)) begin
                n_err++; $display("FAIL drain_order[%0d]: got we=%b %h/%h expected 1 %h/%h", i, mem_we, mem_addr, mem_wd, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            tick();
        end
        n_cmp++; if (empty !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL drain_empty: got empty=%b we=%b expected 1 0", empty, mem_we); end
        mem_ready = 1'b0;
    endtask

    task automatic test_fwd_priority();
        mem_ready = 1'b0;
        put_store(32'h200, 32'h11);
        put_store(32'h200, 32'h22);
        put_store(32'h204, 32'h33);
        ld_addr = 32'h202; #1;
        n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h22) begin n_err++; $display("FAIL fwd_youngest: got %b/%h expected 1/22", ld_fwd_hit, ld_fwd_data); end
        ld_addr = 32'h300; #1;
        n_cmp++; if (ld_fwd_hit !== 1'b0 || ld_fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss: got %b/%h expected 0/0", ld_fwd_hit, ld_fwd_data); end
        ld_addr = 32'h204;
        mem_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h33 || mem_we !== 1'b1) begin n_err++; $display("FAIL fwd_draining: got %b/%h we=%b expected 1/33 we=1", ld_fwd_hit, ld_fwd_data, mem_we); end
        tick();
        n_cmp++; if (ld_fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_after_drain: got %b expected 0", ld_fwd_hit); end
        ld_addr = 32'h200; #1;
        n_cmp++; if (ld_fwd_hit !== 1'b0 || ld_fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_stale: got %b/%h expected 0/0", ld_fwd_hit, ld_fwd_data); end
        mem_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        mem_ready = 1'b0;
        st_valid  = 1'b1;
        st_addr   = 32'h400;
        st_data   = 32'h55;
        ld_addr   = 32'h400;
        #1;
        n_cmp++; if (ld_fwd_hit !== 1'b0) begin n_err++; $display("FAIL same_cycle_hidden: got %b expected 0", ld_fwd_hit); end
        tick();
        st_valid = 1'b0;
        #1;
        n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h55) begin n_err++; $display("FAIL next_cycle_visible: got %b/%h expected 1/55", ld_fwd_hit, ld_fwd_data); end
        drain_all();
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        put_store(32'h700, 32'h70);
        put_store(32'h704, 32'h71);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h708 + 32'(4 * i) + 32'(i % 4);
            st_data  = $urandom_range(32'h7FFF_FFFF, 0);
            tick();
            n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
        end
        st_valid = 1'b0;
        drain_all();
    endtask

    task automatic test_wrap_fwd();
        mem_ready = 1'b0;
        put_store(32'h500, 32'h1);
        put_store(32'h600, 32'h2);
        put_store(32'h501, 32'h3);
        ld_addr = 32'h503; #1;
        n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h3) begin n_err++; $display("FAIL wrap_youngest: got %b/%h expected 1/3", ld_fwd_hit, ld_fwd_data); end
        ld_addr = 32'h600; #1;
        n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h2) begin n_err++; $display("FAIL wrap_single: got %b/%h expected 1/2", ld_fwd_hit, ld_fwd_data); end
        drain_all();
    endtask

    task automatic test_reset_mid_drain();
        mem_ready = 1'b0;
        put_store(32'h800, 32'h80);
        put_store(32'h804, 32'h81);
        put_store(32'h808, 32'h82);
        mem_ready = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL mid_reset: got count=%0d empty=%b we=%b expected 0 1 0", count, empty, mem_we); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL post_reset_write[%0d]: got we=%b expected 0", i, mem_we); end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_and_drain();
        test_fwd_priority();
        test_same_cycle();
        test_back_to_back();
        test_wrap_fwd();
        test_reset_mid_drain();
        tick();
        n_cmp++; if (exp_addr_q.size() != 0) begin n_err++; $display("FAIL leftover_writes: got %0d pending expected 0", exp_addr_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
